// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state, substate and interval codes for the anti-theft alarm
package alarm_pkg;

    // Main state codes; values match the existing SET/OFF/TRIGGER/ON encoding
    localparam logic [1:0] ST_SET     = 2'd0;
    localparam logic [1:0] ST_OFF     = 2'd1;
    localparam logic [1:0] ST_TRIGGER = 2'd2;
    localparam logic [1:0] ST_ON      = 2'd3;

    // Substates tracked while the alarm is disarmed
    localparam logic [1:0] SUB_IGN_ON     = 2'd0;
    localparam logic [1:0] SUB_WAIT_OPEN  = 2'd1;
    localparam logic [1:0] SUB_WAIT_CLOSE = 2'd2;
    localparam logic [1:0] SUB_ARMING     = 2'd3;

    // Interval selects presented to the time_parameters block
    localparam logic [1:0] IV_ARM_DELAY       = 2'd0;
    localparam logic [1:0] IV_DRIVER_DELAY    = 2'd1;
    localparam logic [1:0] IV_PASSENGER_DELAY = 2'd2;
    localparam logic [1:0] IV_ALARM_ON        = 2'd3;

    // A zero-second interval still runs for one second
    function automatic logic [3:0] sec_count(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

endpackage

// File: rtl/anti_theft_fsm_if.sv
// rtl/anti_theft_fsm_if.sv - sensor inputs, timing handshake and indicator outputs of the alarm
interface anti_theft_fsm_if;
    logic       ignition;
    logic       door_driver;
    logic       door_pass;
    logic       reprogram;
    logic [3:0] value;
    logic [1:0] interval;
    logic [1:0] state;
    logic       status;
    logic       siren_on;

    // Vehicle side: drives sensors and interval value, observes alarm outputs
    modport master (
        output ignition, door_driver, door_pass, reprogram, value,
        input  interval, state, status, siren_on
    );

    // Alarm controller side
    modport slave (
        input  ignition, door_driver, door_pass, reprogram, value,
        output interval, state, status, siren_on
    );
endinterface

// File: rtl/sec_timer.sv
// rtl/sec_timer.sv - second divider plus 4-bit seconds down counter with load/stop/expire
module sec_timer
    import alarm_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic       i_stop,
    input  logic [3:0] i_value,
    output logic       o_expire
);
    localparam int             DW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_HZ - 1);

    logic [DW-1:0] r_div;
    logic [3:0]    r_sec;
    logic          r_run;

    // Expire is decoded from state so it lands exactly N*CLK_HZ cycles after the load cycle
    assign o_expire = r_run && (r_div == '0) && (r_sec == 4'd1);

    // Countdown: stop beats load, load restarts, otherwise tick down once per cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
            r_div <= '0;
            r_sec <= 4'd0;
        end else if (i_stop) begin
            r_run <= 1'b0;
        end else if (i_load) begin
            r_run <= 1'b1;
            r_div <= DIV_MAX;
            r_sec <= sec_count(i_value);
        end else if (r_run) begin
            if (r_div == '0) begin
                if (r_sec == 4'd1) begin
                    r_run <= 1'b0;
                end else begin
                    r_sec <= r_sec - 4'd1;
                    r_div <= DIV_MAX;
                end
            end else begin
                r_div <= r_div - DW'(1);
            end
        end
    end
endmodule

// File: rtl/anti_theft_fsm.sv
// rtl/anti_theft_fsm.sv - vehicle anti-theft alarm controller
module anti_theft_fsm
    import alarm_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic             clock,
    input  logic             reset,
    anti_theft_fsm_if.slave  bus
);
    localparam int            DW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_HZ - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_sub;
    logic [1:0]    r_interval;
    logic          r_load_req;
    logic          r_status;
    logic          r_siren;
    logic [DW-1:0] r_blink_cnt;

    logic [1:0]    w_state_nxt;
    logic [1:0]    w_sub_nxt;
    logic [1:0]    w_interval_nxt;
    logic          w_load_nxt;
    logic          w_stop;
    logic          w_enter_set;
    logic          w_expire;
    logic          w_any_door;

    assign w_any_door   = bus.door_driver | bus.door_pass;
    assign bus.state    = r_state;
    assign bus.interval = r_interval;
    assign bus.status   = r_status;
    assign bus.siren_on = r_siren;

    // Timer is loaded the cycle after the interval is registered, so value matches interval
    sec_timer #(.CLK_HZ(CLK_HZ)) u_timer (
        .i_clk    (clock),
        .i_rst_n  (reset),
        .i_load   (r_load_req),
        .i_stop   (w_stop),
        .i_value  (bus.value),
        .o_expire (w_expire)
    );

    // Next-state decision: reprogram > ignition > door events > expire
    always_comb begin
        w_state_nxt    = r_state;
        w_sub_nxt      = r_sub;
        w_interval_nxt = r_interval;
        w_load_nxt     = 1'b0;
        w_stop         = 1'b0;
        w_enter_set    = 1'b0;
        if (bus.reprogram) begin
            w_state_nxt = ST_SET;
            w_stop      = 1'b1;
            w_enter_set = 1'b1;
        end else if (bus.ignition) begin
            w_state_nxt = ST_OFF;
            w_sub_nxt   = SUB_IGN_ON;
            w_stop      = 1'b1;
        end else begin
            case (r_state)
                ST_SET: begin
                    if (bus.door_driver) begin
                        w_state_nxt    = ST_TRIGGER;
                        w_interval_nxt = IV_DRIVER_DELAY;
                        w_load_nxt     = 1'b1;
                    end else if (bus.door_pass) begin
                        w_state_nxt    = ST_TRIGGER;
                        w_interval_nxt = IV_PASSENGER_DELAY;
                        w_load_nxt     = 1'b1;
                    end
                end
                ST_TRIGGER: begin
                    if (w_expire) begin
                        w_state_nxt    = ST_ON;
                        w_interval_nxt = IV_ALARM_ON;
                        w_load_nxt     = 1'b1;
                    end
                end
                ST_ON: begin
                    if (w_any_door) begin
                        w_interval_nxt = IV_ALARM_ON;
                        w_load_nxt     = 1'b1;
                    end else if (w_expire) begin
                        w_state_nxt = ST_SET;
                        w_enter_set = 1'b1;
                    end
                end
                default: begin
                    case (r_sub)
                        SUB_IGN_ON:    w_sub_nxt = SUB_WAIT_OPEN;
                        SUB_WAIT_OPEN: if (bus.door_driver) w_sub_nxt = SUB_WAIT_CLOSE;
                        SUB_WAIT_CLOSE: begin
                            if (!bus.door_driver) begin
                                w_sub_nxt      = SUB_ARMING;
                                w_interval_nxt = IV_ARM_DELAY;
                                w_load_nxt     = 1'b1;
                            end
                        end
                        default: begin
                            if (w_any_door) begin
                                w_sub_nxt = SUB_WAIT_CLOSE;
                                w_stop    = 1'b1;
                            end else if (w_expire) begin
                                w_state_nxt = ST_SET;
                                w_enter_set = 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    // State, registered outputs and SET-mode blink generator
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SET;
            r_sub       <= SUB_IGN_ON;
            r_interval  <= IV_ARM_DELAY;
            r_load_req  <= 1'b0;
            r_status    <= 1'b1;
            r_siren     <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sub      <= w_sub_nxt;
            r_interval <= w_interval_nxt;
            r_load_req <= w_load_nxt;
            r_siren    <= (w_state_nxt == ST_ON);
            if (w_state_nxt == ST_SET) begin
                if (w_enter_set) begin
                    r_status    <= 1'b1;
                    r_blink_cnt <= '0;
                end else if (r_blink_cnt == DIV_MAX) begin
                    r_status    <= ~r_status;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + DW'(1);
                end
            end else begin
                r_status    <= (w_state_nxt != ST_OFF);
                r_blink_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_anti_theft_fsm.sv
// tb/tb_anti_theft_fsm.sv - directed bench with deadline-based behavioural model of the alarm
module tb_anti_theft_fsm;
    localparam int C = 4;
    localparam int M_SET = 0, M_OFF = 1, M_TRIG = 2, M_ON = 3;
    localparam int S_IGN = 0, S_WOPEN = 1, S_WCLOSE = 2, S_ARM = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    anti_theft_fsm_if bus ();

    anti_theft_fsm #(.CLK_HZ(C)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Model: state plus absolute cycle deadlines instead of counters
    int k = 0;
    int m_state, m_sub, m_iv, m_deadline, m_set_entry;
    bit m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_SET; m_sub = S_IGN; m_iv = 0;
        m_pend = 0; m_deadline = -1; m_set_entry = k + 1;
    endtask

    function automatic int model_status();
        if (!reset) return 1;
        if (m_state == M_SET) return (((k - m_set_entry) / C) % 2 == 0) ? 1 : 0;
        return (m_state == M_OFF) ? 0 : 1;
    endfunction

    task automatic model_step();
        bit exp_now = (m_deadline == k);
        bit stop = 0;
        bit np = 0;
        bit door = bus.door_driver | bus.door_pass;
        int v = int'(bus.value);
        if (bus.reprogram) begin
            m_state = M_SET; stop = 1; m_set_entry = k + 1;
        end else if (bus.ignition) begin
            m_state = M_OFF; m_sub = S_IGN; stop = 1;
        end else if (m_state == M_SET) begin
            if (bus.door_driver) begin m_state = M_TRIG; m_iv = 1; np = 1; end
            else if (bus.door_pass) begin m_state = M_TRIG; m_iv = 2; np = 1; end
        end else if (m_state == M_TRIG) begin
            if (exp_now) begin m_state = M_ON; m_iv = 3; np = 1; end
        end else if (m_state == M_ON) begin
            if (door) begin m_iv = 3; np = 1; end
            else if (exp_now) begin m_state = M_SET; m_set_entry = k + 1; end
        end else begin
            if (m_sub == S_IGN) m_sub = S_WOPEN;
            else if (m_sub == S_WOPEN) begin if (bus.door_driver) m_sub = S_WCLOSE; end
            else if (m_sub == S_WCLOSE) begin
                if (!bus.door_driver) begin m_sub = S_ARM; m_iv = 0; np = 1; end
            end else begin
                if (door) begin m_sub = S_WCLOSE; stop = 1; end
                else if (exp_now) begin m_state = M_SET; m_set_entry = k + 1; end
            end
        end
        if (stop) m_deadline = -1;
        else if (m_pend) m_deadline = k + ((v == 0) ? 1 : v) * C;
        m_pend = np;
    endtask

    always @(negedge reset) model_reset();

    always @(posedge clock) begin
        if (!reset) model_reset();
        else model_step();
        k++;
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        check("cyc_state",    bus.state,    m_state);
        check("cyc_interval", bus.interval, m_iv);
        check("cyc_status",   bus.status,   model_status());
        check("cyc_siren",    bus.siren_on, (m_state == M_ON && reset) ? 1 : 0);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    logic [15:0] blink_pat;

    initial begin
        bus.ignition = 0; bus.door_driver = 0; bus.door_pass = 0;
        bus.reprogram = 0; bus.value = 4'd0;
        model_reset();
        repeat (3) step();
        check("rst_state", bus.state, 0);
        check("rst_status", bus.status, 1);
        check("rst_siren", bus.siren_on, 0);
        check("rst_interval", bus.interval, 0);
        reset = 1;
        #1;
        // Idle SET blink: 1111 0000 1111 0000
        blink_pat = 16'b1111_0000_1111_0000;
        for (int i = 0; i < 16; i++) begin
            check("blink", bus.status, blink_pat[15 - i]);
            step();
        end

        // Driver door in SET: TRIGGER, 12-cycle delay, then ON
        bus.value = 4'd3; bus.door_driver = 1; step(); bus.door_driver = 0;
        check("drv_trig_state", bus.state, 2);
        check("drv_trig_iv", bus.interval, 1);
        repeat (12) step();
        check("drv_pre_on", bus.state, 2);
        step();
        check("drv_on_state", bus.state, 3);
        check("drv_on_siren", bus.siren_on, 1);
        check("drv_on_iv", bus.interval, 3);

        // Reprogram beats ignition in ON
        step(); step();
        bus.ignition = 1; bus.reprogram = 1; step(); bus.ignition = 0; bus.reprogram = 0;
        check("rp_state", bus.state, 0);
        check("rp_siren", bus.siren_on, 0);
        check("rp_status", bus.status, 1);

        // Both doors together select the driver delay
        bus.door_driver = 1; bus.door_pass = 1; step(); bus.door_driver = 0; bus.door_pass = 0;
        check("both_state", bus.state, 2);
        check("both_iv", bus.interval, 1);
        bus.reprogram = 1; step(); bus.reprogram = 0;
        check("both_back", bus.state, 0);

        // Passenger door, value 0 -> 4 cycles; ON held by open door, then 8 cycles after closing
        bus.value = 4'd0; bus.door_pass = 1; step();
        check("pas_state", bus.state, 2);
        check("pas_iv", bus.interval, 2);
        repeat (4) step();
        check("pas_pre_on", bus.state, 2);
        step();
        check("pas_on", bus.state, 3);
        step(); step();
        bus.value = 4'd2; bus.door_pass = 0;
        repeat (8) step();
        check("close_still_on", bus.state, 3);
        check("close_siren_on", bus.siren_on, 1);
        step();
        check("close_set", bus.state, 0);
        check("close_siren_off", bus.siren_on, 0);

        // OFF arming sequence, value 2 -> 8 cycles after load
        bus.ignition = 1; step(); bus.ignition = 0;
        check("off_state", bus.state, 1);
        check("off_status", bus.status, 0);
        step();
        bus.door_driver = 1; step(); bus.door_driver = 0; step();
        check("arm_iv", bus.interval, 0);
        repeat (8) step();
        check("arm_pre_set", bus.state, 1);
        step();
        check("arm_set", bus.state, 0);
        check("arm_status", bus.status, 1);

        // Door reopened during arming abandons the countdown
        bus.ignition = 1; step(); bus.ignition = 0; step();
        bus.door_driver = 1; step(); bus.door_driver = 0; step();
        repeat (5) step();
        bus.door_driver = 1; repeat (6) step();
        check("reopen_off", bus.state, 1);
        bus.door_driver = 0; step();
        bus.reprogram = 1; step(); bus.reprogram = 0;
        check("reopen_rp", bus.state, 0);

        // Asynchronous reset mid-TRIGGER
        bus.value = 4'd3; bus.door_driver = 1; step(); bus.door_driver = 0;
        check("rtrig_state", bus.state, 2);
        step(); step();
        #2; reset = 0; #1;
        check("arst_state", bus.state, 0);
        check("arst_status", bus.status, 1);
        check("arst_siren", bus.siren_on, 0);
        check("arst_iv", bus.interval, 0);
        step();
        reset = 1;
        repeat (20) step();
        check("no_stale", bus.state, 0);
        bus.door_pass = 1; step(); bus.door_pass = 0;
        check("post_rst_state", bus.state, 2);
        check("post_rst_iv", bus.interval, 2);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/anti_theft_fsm.md
ANTI_THEFT_FSM -- requirements
Module: anti_theft_fsm

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, clock cycles per second.
REQ-002 SHALL have port clock  in  1  single system clock, all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ignition, door_driver, door_pass, reprogram  in  1 each  debounced, synchronous, active-high.
REQ-005 SHALL have port value  in  4  seconds for the requested interval, returned by time_parameters.
REQ-006 SHALL have port interval  out  2  interval select to time_parameters: 0 T_ARM_DELAY, 1 T_DRIVER_DELAY, 2 T_PASSENGER_DELAY, 3 T_ALARM_ON.
REQ-007 SHALL have port state  out  2  current state: 0 SET (armed), 1 OFF (disarmed), 2 TRIGGER, 3 ON (siren).
REQ-008 SHALL have ports status  out  1  (LED) and siren_on  out  1  (enable to siren driver), both registered.

Function
REQ-009 Timer SHALL load on a load pulse, latching value, and pulse expire for one cycle exactly max(value,1)*CLK_HZ cycles after the load cycle; a new load restarts it.
REQ-010 On any state transition needing a timer, interval SHALL be registered in the transition cycle and the timer loaded in the following cycle (value sampled then).
REQ-011 Priority per cycle SHALL be: reprogram > ignition > door events > expire.
REQ-012 reprogram=1 in any state SHALL force SET, stop the timer, drop siren_on.
REQ-013 ignition=1 in SET, TRIGGER or ON SHALL go to OFF, substate IGN_ON, siren_on=0 next cycle.
REQ-014 SET: door_driver=1 -> TRIGGER with interval 1; else door_pass=1 -> TRIGGER with interval 2; both same cycle -> interval 1.
REQ-015 TRIGGER: expire -> ON, interval 3; further door events ignored.
REQ-016 ON: siren_on=1; while any door open, timer reloaded every cycle with interval 3; after both closed, expire -> SET.
REQ-017 OFF substates: IGN_ON -(ignition=0)-> WAIT_OPEN -(door_driver=1)-> WAIT_CLOSE -(door_driver=0)-> ARMING (load interval 0).
REQ-018 ARMING: any door open -> WAIT_CLOSE (timer abandoned); expire -> SET; ignition=1 in any OFF substate -> IGN_ON.
REQ-019 status SHALL be: SET blinking (1 for CLK_HZ cycles, 0 for CLK_HZ, starting 1 on entry); OFF 0; TRIGGER and ON 1.
REQ-020 siren_on SHALL be 1 only in ON; expire arriving when not expected SHALL be ignored.

Reset
REQ-021 reset=0 SHALL immediately force state SET, status 1, siren_on 0, interval 0, OFF substate IGN_ON, timer idle, blink phase 0.
REQ-022 Reset release mid-countdown SHALL leave no stale expire; first event follows REQ-014.

Structure
REQ-023 State codes, OFF substate codes and interval codes SHALL live in shared package alarm_pkg, with state codes matching the existing SET/OFF/TRIGGER/ON encoding.
REQ-024 Timer (second divider + 4-bit down counter, load/expire) SHALL be sub-module sec_timer, parameterised by CLK_HZ.

Verification (CLK_HZ=4)
REQ-025 Reset, then door_driver=1 with value=3 -> state TRIGGER next cycle, interval=1, expire 12 cycles after load, state ON, siren_on=1.
REQ-026 SET, door_pass=1, value=0 -> interval=2, ON after 4 cycles from load; close doors, value=2 -> SET 8 cycles after closing, siren_on=0.
REQ-027 ON with ignition=1 and reprogram=1 same cycle -> SET (reprogram wins), siren_on=0.
REQ-028 OFF: ignition 0, driver door open then closed, value=2 -> SET 8 cycles after load; reopen door at cycle 5 -> WAIT_CLOSE, no arming.
REQ-029 SET idle 16 cycles -> status pattern 1111 0000 1111 0000; assert reset mid-TRIGGER -> SET, status 1 immediately.
